// File: rtl/mem_pkg.sv
// Shared definitions for the data RAM port arbiter.
// Op codes, state encoding and RAM address width.
package mem_pkg;

  localparam int MEM_AW = 15;

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_WB   = 2'd1;
  localparam logic [1:0] OP_WH   = 2'd2;
  localparam logic [1:0] OP_WW   = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin picker with optional lock holder.
// Purely combinational; output grant is one-hot or zero.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       lock_vld_i,
  input  logic       lock_id_i,
  output logic [1:0] gnt_o
);

  // Lock holder first, then the requester that did not win last time.
  always_comb begin
    gnt_o = 2'b00;
    if (lock_vld_i && req_i[lock_id_i]) begin
      gnt_o = lock_id_i ? 2'b10 : 2'b01;
    end else if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for one port of the data RAM.
// Grant locking is compiled in only when MEM_ARB_LOCK_EN is defined.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [1:0]    m0_op,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [1:0]    m1_op,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_cs,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_op,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_e        state_q;
  logic          last_q;
  logic          own_q;
  logic          cs_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    op_q;
  logic [DW-1:0] wdata_q;
  logic [1:0]    done_q;
  logic [DW-1:0] rd0_q;
  logic [DW-1:0] rd1_q;

  logic [1:0] req;
  logic [1:0] arb_gnt;
  logic [1:0] gnt;
  logic       win;
  logic       lock_vld;
  logic       lock_id;

  assign req = {m1_req, m0_req};
  assign gnt = (state_q == ST_IDLE && !rst) ? arb_gnt : 2'b00;
  assign win = gnt[1];

`ifdef MEM_ARB_LOCK_EN
  logic lockv_q;
  logic lockid_q;

  // Every grant re-decides the lock from the winner's lock input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lockv_q  <= 1'b0;
      lockid_q <= 1'b0;
    end else if (|gnt) begin
      lockv_q  <= win ? m1_lock : m0_lock;
      lockid_q <= win;
    end
  end

  assign lock_vld = lockv_q;
  assign lock_id  = lockid_q;
`else
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
  assign lock_vld    = 1'b0;
  assign lock_id     = 1'b0;
`endif

  rr_arb2 u_arb (
    .req_i      (req),
    .last_i     (last_q),
    .lock_vld_i (lock_vld),
    .lock_id_i  (lock_id),
    .gnt_o      (arb_gnt)
  );

  // IDLE latches the winner; ACCESS drives the RAM for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      cs_q    <= 1'b0;
      addr_q  <= '0;
      op_q    <= OP_READ;
      wdata_q <= '0;
      done_q  <= 2'b00;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      done_q <= 2'b00;
      cs_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            state_q <= ST_ACCESS;
            cs_q    <= 1'b1;
            own_q   <= win;
            last_q  <= win;
            addr_q  <= win ? m1_addr : m0_addr;
            op_q    <= win ? m1_op : m0_op;
            wdata_q <= win ? m1_wdata : m0_wdata;
          end
        end
        ST_ACCESS: begin
          state_q <= ST_IDLE;
          done_q  <= own_q ? 2'b10 : 2'b01;
          if (op_q == OP_READ) begin
            if (own_q) rd1_q <= mem_rdata;
            else       rd0_q <= mem_rdata;
          end
        end
      endcase
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_done   = done_q[0];
  assign m1_done   = done_q[1];
  assign m0_rdata  = rd0_q;
  assign m1_rdata  = rd1_q;
  assign mem_cs    = cs_q;
  assign busy      = cs_q;
  assign mem_addr  = addr_q;
  assign mem_op    = op_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model plus directed cases.
// Lock scenario runs only when MEM_ARB_LOCK_EN is defined.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int AW = 15;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          rq [2] = '{1'b0, 1'b0};
  logic [AW-1:0] ad [2] = '{'0, '0};
  logic [1:0]    opv[2] = '{2'd0, 2'd0};
  logic [DW-1:0] wd [2] = '{'0, '0};
  logic          lk [2] = '{1'b0, 1'b0};

  logic          m0_gnt, m0_done, m1_gnt, m1_done;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_cs, busy;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_op;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(rq[0]), .m0_addr(ad[0]), .m0_op(opv[0]),
    .m0_wdata(wd[0]), .m0_lock(lk[0]),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(rq[1]), .m1_addr(ad[1]), .m1_op(opv[1]),
    .m1_wdata(wd[1]), .m1_lock(lk[1]),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_op(mem_op),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] op);
    return (op == 2'd1) ? 1 : (op == 2'd2) ? 2 : (op == 2'd3) ? 4 : 0;
  endfunction

  // Environment RAM driven by the DUT's port signals
  logic [7:0] ram[32768];
  logic [7:0] shd[32768];

  assign mem_rdata = {ram[{mem_addr[14:2], 2'd3}], ram[{mem_addr[14:2], 2'd2}],
                      ram[{mem_addr[14:2], 2'd1}], ram[{mem_addr[14:2], 2'd0}]};

  always @(posedge clk) begin
    if (mem_cs && mem_op != 2'd0) begin
      for (int b = 0; b < 4; b++)
        if (b < nbytes(mem_op))
          ram[{mem_addr[14:2], 2'(mem_addr[1:0] + 2'(b))}] <= mem_wdata[8*b +: 8];
    end
  end

  // Transaction-level reference model
  logic          m_last = 1'b1;
  logic          m_acc  = 1'b0;
  logic          m_own  = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [1:0]    m_op   = '0;
  logic [DW-1:0] m_wd   = '0;
  logic          m_dv   = 1'b0;
  logic          m_down = 1'b0;
  logic [DW-1:0] m_rd[2] = '{'0, '0};
  logic          m_lv   = 1'b0;
  logic          m_lid  = 1'b0;

  always @(negedge clk) begin
    logic [1:0] eg;
    logic w;
    if (rst) begin
      m_last = 1'b1; m_acc = 1'b0; m_dv = 1'b0;
      m_rd[0] = '0; m_rd[1] = '0; m_lv = 1'b0; m_lid = 1'b0;
      chk("rst_cs_busy", {30'd0, busy, mem_cs}, 32'd0);
      chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      chk("rst_done", {30'd0, m1_done, m0_done}, 32'd0);
      chk("rst_rd0", m0_rdata, 32'd0);
      chk("rst_rd1", m1_rdata, 32'd0);
      chk("rst_mem", {15'd0, mem_op, mem_addr}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
    end else begin
      eg = 2'b00;
      if (!m_acc) begin
`ifdef MEM_ARB_LOCK_EN
        if (m_lv && rq[m_lid]) eg[m_lid] = 1'b1;
        else
`endif
        if (rq[0] && rq[1]) eg[!m_last] = 1'b1;
        else eg = {rq[1], rq[0]};
      end
      chk("gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, eg});
      chk("cs_busy", {30'd0, busy, mem_cs}, {30'd0, m_acc, m_acc});
      if (m_acc) begin
        chk("mem_addr", {17'd0, mem_addr}, {17'd0, m_addr});
        chk("mem_op", {30'd0, mem_op}, {30'd0, m_op});
        if (m_op != 2'd0) chk("mem_wdata", mem_wdata, m_wd);
      end
      chk("done", {30'd0, m1_done, m0_done},
          m_dv ? (m_down ? 32'd2 : 32'd1) : 32'd0);
      chk("rd0", m0_rdata, m_rd[0]);
      chk("rd1", m1_rdata, m_rd[1]);
      // advance model to the next cycle
      m_dv = m_acc;
      m_down = m_own;
      if (m_acc) begin
        if (m_op == 2'd0)
          m_rd[m_own] = {shd[{m_addr[14:2], 2'd3}], shd[{m_addr[14:2], 2'd2}],
                         shd[{m_addr[14:2], 2'd1}], shd[{m_addr[14:2], 2'd0}]};
        else
          for (int b = 0; b < nbytes(m_op); b++)
            shd[{m_addr[14:2], 2'(m_addr[1:0] + 2'(b))}] = m_wd[8*b +: 8];
      end
      if (eg != 2'b00) begin
        w = eg[1];
        m_acc = 1'b1; m_own = w; m_last = w;
        m_addr = ad[w]; m_op = opv[w]; m_wd = wd[w];
        m_lv = lk[w]; m_lid = w;
      end else begin
        m_acc = 1'b0;
      end
    end
  end

  function automatic logic gnt_of(input int i);
    return (i == 0) ? m0_gnt : m1_gnt;
  endfunction

  function automatic logic done_of(input int i);
    return (i == 0) ? m0_done : m1_done;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    rq[0] = 1'b0; rq[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One request: raise, wait grant, drop, wait done.
  task automatic txn(input int i, input logic [AW-1:0] a, input logic [1:0] o,
                     input logic [DW-1:0] w, output int gc, output int dc,
                     output logic [AW-1:0] sa, output logic [1:0] so);
    @(posedge clk); #1;
    rq[i] = 1'b1; ad[i] = a; opv[i] = o; wd[i] = w; lk[i] = 1'b0;
    gc = -1; dc = -1; sa = '0; so = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gnt_of(i)) begin gc = cyc; break; end
    end
    chk("gnt_seen", {31'd0, gc >= 0}, 32'd1);
    @(posedge clk); #1;
    rq[i] = 1'b0;
    @(negedge clk);
    sa = mem_addr; so = mem_op;
    for (int k = 0; k < 10; k++) begin
      if (done_of(i)) begin dc = cyc; break; end
      @(negedge clk);
    end
    chk("done_seen", {31'd0, dc >= 0}, 32'd1);
  endtask

  // Keep req high for n grants, changing payload right after each grant.
  task automatic stream(input int i, input int n, input logic [7:0] lmask,
                        output int lastg);
    @(posedge clk); #1;
    rq[i] = 1'b1; ad[i] = 15'(12'h200 + $urandom_range(0, 31));
    opv[i] = 2'($urandom_range(0, 3)); wd[i] = $urandom; lk[i] = lmask[0];
    lastg = -1;
    for (int g = 0; g < n; g++) begin
      int gc = -1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (gnt_of(i)) begin gc = cyc; break; end
      end
      chk("stream_gnt", {31'd0, gc >= 0}, 32'd1);
      lastg = gc;
      @(posedge clk); #1;
      if (g == n - 1) rq[i] = 1'b0;
      else begin
        ad[i] = 15'(12'h200 + $urandom_range(0, 31));
        opv[i] = 2'($urandom_range(0, 3)); wd[i] = $urandom;
        lk[i] = lmask[g + 1];
      end
    end
  endtask

  task automatic rand_drv(input int i, input int n);
    logic g;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      g = gnt_of(i);
      @(posedge clk); #1;
      if ((rq[i] && g) || !rq[i]) begin
        rq[i] = ($urandom_range(0, 2) != 0);
        ad[i] = 15'($urandom_range(0, 63));
        opv[i] = 2'($urandom_range(0, 3));
        wd[i] = $urandom; lk[i] = 1'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        rq[i] = 1'b0;
      end
    end
    @(posedge clk); #1 rq[i] = 1'b0;
  endtask

  // Grant log for the alternation check
  int gq[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_gnt) gq.push_back(0);
      if (m1_gnt) gq.push_back(1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, d0, g1, d1, base, lg;
    logic [AW-1:0] sa, sa1;
    logic [1:0] so, so1;
    for (int i = 0; i < 32768; i++) begin
      ram[i] = 8'($urandom);
      shd[i] = ram[i];
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // m0 word write then read back
    txn(0, 15'h0040, 2'd3, 32'hDEADBEEF, g0, d0, sa, so);
    chk("w_lat", d0 - g0, 32'd2);
    chk("w_addr", {17'd0, sa}, 32'h40);
    chk("w_op", {30'd0, so}, 32'd3);
    txn(0, 15'h0040, 2'd0, 32'd0, g0, d0, sa, so);
    chk("r_lat", d0 - g0, 32'd2);
    chk("r_data", m0_rdata, 32'hDEADBEEF);

    // m1 byte lane merge
    txn(1, 15'h0000, 2'd3, 32'h11223344, g1, d1, sa, so);
    txn(1, 15'h0003, 2'd1, 32'h000000AB, g1, d1, sa, so);
    txn(1, 15'h0000, 2'd0, 32'd0, g1, d1, sa, so);
    chk("m1_merge", m1_rdata, 32'hAB223344);
    chk("m0_hold", m0_rdata, 32'hDEADBEEF);

    // simultaneous requests from reset
    do_reset();
    fork
      txn(0, 15'h0100, 2'd0, 32'd0, g0, d0, sa, so);
      txn(1, 15'h0104, 2'd0, 32'd0, g1, d1, sa1, so1);
    join
    chk("tie_order", g1 - g0, 32'd2);

    // both held for 8 grants
    base = gq.size();
    fork
      stream(0, 4, 8'h00, lg);
      stream(1, 4, 8'h00, lg);
    join
    chk("alt_count", gq.size() - base, 32'd8);
    for (int j = 0; j < 8 && base + j < gq.size(); j++)
      chk("alt_seq", gq[base + j], j % 2);

    // reset in the middle of an access
    @(posedge clk); #1;
    rq[0] = 1'b1; ad[0] = 15'h0300; opv[0] = 2'd3; wd[0] = 32'h55AA55AA;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m0_gnt) break;
    end
    @(posedge clk); #1;
    rst = 1'b1; rq[0] = 1'b0;
    #1 chk("rst_cs_now", {31'd0, mem_cs}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_nodone", {30'd0, m1_done, m0_done}, 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    fork
      txn(0, 15'h0010, 2'd0, 32'd0, g0, d0, sa, so);
      txn(1, 15'h0014, 2'd0, 32'd0, g1, d1, sa1, so1);
    join
    chk("rst_first", g1 - g0, 32'd2);

`ifdef MEM_ARB_LOCK_EN
    do_reset();
    fork
      stream(0, 4, 8'h07, lg);
      txn(1, 15'h0020, 2'd0, 32'd0, g1, d1, sa1, so1);
    join
    chk("lock_order", g1 - lg, 32'd2);
`endif

    // randomized traffic
    fork
      rand_drv(0, 1500);
      rand_drv(1, 1500);
    join
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
